// File: rtl/exp_result_serializer.sv
// exp_result_serializer
//   Buffers full-width results from the exponent pipeline in a small FIFO and
//   drains each one as BEATS narrow beats, LSB first, over a valid/ready
//   master port. The producer cannot be stalled; results that arrive while
//   the FIFO is full and no pop happens are dropped and flagged.
//
//   Handshake: a beat transfers on a rising clk edge where m_valid && m_ready.
//   Once m_valid is high it stays high, and m_data/m_last stay stable, until
//   that beat transfers.
//
//   Optional build macro: EXP_SER_CNT_EN adds o_result_cnt, a wrapping count
//   of completed (last-beat) transfers.
module exp_result_serializer #(
    parameter int DEPTH = 8,
    parameter int W_IN  = 64,
    parameter int W_OUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [W_IN-1:0]          i_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [W_OUT-1:0]         m_data,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   o_level,
`ifdef EXP_SER_CNT_EN
    output logic [15:0]              o_result_cnt,
`endif
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int BEATS = W_IN / W_OUT;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state, next_state;
    logic [W_IN-1:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic [W_IN-1:0]   shifter;
    logic [BW-1:0]     beat;
    logic              last_beat;
    logic              push, pop;

    assign o_level   = level;
    assign o_full    = (level == LW'(DEPTH));
    assign o_empty   = (level == '0);
    assign last_beat = (beat == BW'(BEATS - 1));

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign push = i_valid && (!o_full || pop);

    // Next-state, pop decision and beat outputs.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty) begin
                    pop        = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = shifter[W_OUT-1:0];
                m_last  = last_beat;
                if (m_ready && last_beat) begin
                    // Back-to-back results: reload the shifter without a bubble.
                    if (!o_empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers (wrap naturally at DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Output shifter: load on pop, shift right one beat per non-final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '0;
            beat    <= '0;
        end else if (pop) begin
            shifter <= mem[rd_ptr];
            beat    <= '0;
        end else if (state == SEND && m_ready && !last_beat) begin
            shifter <= shifter >> W_OUT;
            beat    <= beat + BW'(1);
        end
    end

    // Sticky drop flag: set when a result arrives with nowhere to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_valid && o_full && !pop) begin
            o_overflow <= 1'b1;
        end
    end

`ifdef EXP_SER_CNT_EN
    // Completed-result counter, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_result_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            o_result_cnt <= o_result_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exp_result_serializer.sv
// Testbench for exp_result_serializer (default parameters: DEPTH 8, 64 -> 16).
// Table-driven single-result sequence, hand-written multi-cycle corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_exp_result_serializer;

    localparam int DEPTH = 8;
    localparam int W_IN  = 64;
    localparam int W_OUT = 16;
    localparam int BEATS = W_IN / W_OUT;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic [W_IN-1:0]   i_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [W_OUT-1:0]  m_data;
    logic              m_last;
    logic [3:0]        o_level;
    logic              o_full;
    logic              o_empty;
    logic              o_overflow;
`ifdef EXP_SER_CNT_EN
    logic [15:0]       o_result_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    exp_result_serializer #(.DEPTH(DEPTH), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .o_level    (o_level),
`ifdef EXP_SER_CNT_EN
        .o_result_cnt(o_result_cnt),
`endif
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // mq : results held in the FIFO, arrival order
    // cur: beats of the result currently being presented, next beat first
    logic [W_IN-1:0]  mq[$];
    logic [W_OUT-1:0] cur[$];
    bit               m_ovf;
    logic [15:0]      m_cnt;

    // observed handshakes and expected beats
    logic [W_OUT-1:0] got_q[$];
    logic [W_OUT-1:0] exp_q[$];

    task automatic model_reset();
        mq.delete();
        cur.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    // Advance the model by one clock edge given the inputs of that cycle.
    task automatic model_edge(input bit iv, input logic [W_IN-1:0] id, input bit rdy);
        bit cur_empty, hs, last_hs, pop_now, room;
        logic [W_IN-1:0] w;
        cur_empty = (cur.size() == 0);
        hs        = !cur_empty && rdy;
        last_hs   = hs && (cur.size() == 1);
        if (hs) void'(cur.pop_front());
        if (last_hs) m_cnt = m_cnt + 16'd1;
        pop_now = (cur_empty || last_hs) && (mq.size() > 0);
        room    = (mq.size() < DEPTH) || pop_now;
        if (pop_now) begin
            w = mq.pop_front();
            for (int b = 0; b < BEATS; b++) cur.push_back(w[b*W_OUT +: W_OUT]);
        end
        if (iv) begin
            if (room) mq.push_back(id);
            else      m_ovf = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        bit ev, el;
        logic [W_OUT-1:0] ed;
        logic [24:0] got, exp;
        ev  = (cur.size() != 0);
        ed  = ev ? cur[0] : '0;
        el  = ev && (cur.size() == 1);
        got = {m_valid, (m_valid ? m_data : 16'h0), (m_valid ? m_last : 1'b0),
               o_level, o_full, o_empty, o_overflow};
        exp = {ev, ed, el, 4'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
        check("model{valid,data,last,level,full,empty,ovf}", 64'(got), 64'(exp));
`ifdef EXP_SER_CNT_EN
        check("model result_cnt", 64'(o_result_cnt), 64'(m_cnt));
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive inputs, record a handshake, clock once,
    // update the model, then compare at the next falling edge.
    task automatic step(input bit iv, input logic [W_IN-1:0] id, input bit rdy);
        i_valid = iv;
        i_data  = id;
        m_ready = rdy;
        if (m_valid && rdy) got_q.push_back(m_data);
        @(posedge clk);
        model_edge(iv, id, rdy);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", 64'({m_valid, m_data, m_last, o_level, o_full, o_empty, o_overflow}),
              64'({1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}));
`ifdef EXP_SER_CNT_EN
        check("reset result_cnt", 64'(o_result_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- table-driven single result ----------------
    typedef struct {
        bit               iv;
        logic [W_IN-1:0]  id;
        bit               rdy;
        bit               ev;
        logic [W_OUT-1:0] ed;
        bit               el;
        logic [3:0]       elev;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [W_IN-1:0] d1;
        int lev_exp[12];
        int n;
        int dens, rdens;

        d1 = 64'h0123_4567_89AB_CDEF;
        // outputs expected at this falling edge, inputs driven for the next edge
        tbl[0] = '{1'b1, d1,    1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 64'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd1};
        tbl[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'hCDEF, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'h89AB, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'h4567, 1'b0, 4'd0};
        tbl[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 16'h0123, 1'b1, 4'd0};
        tbl[6] = '{1'b0, 64'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};

        // 1: single result, sink always ready
        do_reset();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("single vec%0d {valid,data,last,level}", i),
                  64'({m_valid, (m_valid ? m_data : 16'h0), (m_valid ? m_last : 1'b0), o_level}),
                  64'({tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].elev}));
            step(tbl[i].iv, tbl[i].id, tbl[i].rdy);
        end
        check("single handshakes", 64'(got_q.size()), 64'd4);

        // 2: sink stalls 5 cycles while beat 1 is presented
        do_reset();
        step(1'b1, d1, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall hold data c%0d", i), 64'({m_valid, m_data}), 64'({1'b1, 16'h89AB}));
            step(1'b0, '0, 1'b0);
        end
        repeat (6) step(1'b0, '0, 1'b1);
        exp_q = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        check("stall handshake count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check($sformatf("stall beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        // 3: 12 back-to-back pushes, last one dropped
        do_reset();
        lev_exp = '{1, 1, 2, 3, 4, 4, 5, 6, 7, 7, 8, 8};
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 64'(i), 1'b1);
            check($sformatf("burst level after edge %0d", i), 64'(o_level), 64'(lev_exp[i]));
        end
        n = 0;
        while ((got_q.size() < 44 || m_valid) && n < 100) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("burst drain within budget", 64'(n < 100), 64'd1);
        check("burst overflow", 64'(o_overflow), 64'd1);
        check("burst beat count", 64'(got_q.size()), 64'd44);
        for (int k = 0; k < 11; k++) begin
            exp_q.push_back(16'(k));
            repeat (BEATS - 1) exp_q.push_back(16'h0);
        end
        for (int i = 0; i < 44 && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i])
                check($sformatf("burst beat%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        // 4: full FIFO, push coincident with the last-beat handshake
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 64'hA0 + 64'(i), 1'b0);
        check("fill level/full", 64'({o_level, o_full}), 64'({4'd8, 1'b1}));
        n = 0;
        while (!m_last && n < 10) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        check("fill reached last beat", 64'(m_last), 64'd1);
        step(1'b1, 64'hBEEF, 1'b1);
        check("full push on last beat {level,full,ovf}", 64'({o_level, o_full, o_overflow}),
              64'({4'd8, 1'b1, 1'b0}));

        // 5: asynchronous reset during beat 2 with 3 results queued
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 64'h1111_2222_3333_4444 * 64'(i + 1), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("pre-reset beat2 {valid,data,level}", 64'({m_valid, m_data, o_level}),
              64'({1'b1, 16'h2222, 4'd3}));
        #2 rst_n = 1'b0;
        #1 check("async reset {valid,level,empty}", 64'({m_valid, o_level, o_empty}),
                 64'({1'b0, 4'd0, 1'b1}));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        repeat (6) step(1'b0, '0, 1'b1);
        check("no stale beats after reset", 64'(got_q.size()), 64'd0);

`ifdef EXP_SER_CNT_EN
        // 6: result counter
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 64'hC0DE + 64'(i), 1'b1);
        repeat (16) step(1'b0, '0, 1'b1);
        check("result_cnt after 3", 64'(o_result_cnt), 64'd3);
        do_reset();
`endif

        // randomized traffic against the model
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            dens  = $urandom_range(10, 100);
            rdens = $urandom_range(10, 100);
            for (int c = 0; c < 100; c++)
                step($urandom_range(0, 99) < dens, {$urandom, $urandom},
                     $urandom_range(0, 99) < rdens);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
